// File: rtl/rf_access_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_access_sched_if
// Purpose  : Bundles the requester and register-file signals of the
//            register file port scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_access_sched_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic [4:0]    IDBS;
    logic          LCS_n;
    logic          WRTRF;
    logic          PREQ;
    logic          PWR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] RF_DATA;
    logic          RRF_n;
    logic          WRF_n;
    logic          ERF_n;
    logic          ADDR_SEL;
    logic [AW-1:0] PADDR_Q;
    logic          STALL_n;
    logic          PACK;
    logic [DW-1:0] PDATA;

    // Requester / register-file side.
    modport master (
        output IDBS, LCS_n, WRTRF, PREQ, PWR, PADDR, RF_DATA,
        input  RRF_n, WRF_n, ERF_n, ADDR_SEL, PADDR_Q, STALL_n, PACK, PDATA
    );

    // Scheduler side.
    modport slave (
        input  IDBS, LCS_n, WRTRF, PREQ, PWR, PADDR, RF_DATA,
        output RRF_n, WRF_n, ERF_n, ADDR_SEL, PADDR_Q, STALL_n, PACK, PDATA
    );
endinterface
`default_nettype wire

// File: rtl/rf_access_sched.sv
`default_nettype none
// ============================================================================
// Module   : rf_access_sched
// Purpose  : Grants the single register file port to microcode write, microcode
//            read or the panel, with a starvation guard for the panel.
// Revision : 1.0 - initial release
// ============================================================================
module rf_access_sched #(
    parameter int STARVE_LIMIT = 4,
    parameter int DW           = 16,
    parameter int AW           = 4
) (
    input  wire                  sysclk,
    input  wire                  sys_rst_n,
    rf_access_sched_if.slave     bus
);

    typedef enum logic [2:0] {
        OP_IDLE   = 3'd0,
        OP_CPU_RD = 3'd1,
        OP_CPU_WR = 3'd2,
        OP_PNL_RD = 3'd3,
        OP_PNL_WR = 3'd4
    } op_t;

    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    op_t           r_op;
    logic          r_rrf_n;
    logic          r_wrf_n;
    logic          r_addr_sel;
    logic          r_pack;
    logic          r_pnl_busy;
    logic [3:0]    r_starve_cnt;
    logic [AW-1:0] r_paddr_q;
    logic [DW-1:0] r_pdata;

    logic w_cpu_rd;
    logic w_cpu_wr;
    logic w_pnl;
    logic w_force;
    logic w_pnl_grant;
    logic w_op_is_pnl;
    op_t  w_op_nxt;

    assign w_cpu_rd    = bus.LCS_n && (bus.IDBS == 5'd5);
    assign w_cpu_wr    = bus.WRTRF;
    // A PREQ still high during PACK belongs to the finished transaction.
    assign w_pnl       = bus.PREQ && !r_pack && !r_pnl_busy;
    assign w_force     = w_pnl && (r_starve_cnt == c_LIMIT);
    assign w_pnl_grant = w_force || (w_pnl && !w_cpu_wr && !w_cpu_rd);
    assign w_op_is_pnl = (r_op == OP_PNL_RD) || (r_op == OP_PNL_WR);

    always_comb begin
        w_op_nxt = OP_IDLE;
        if (w_force)
            w_op_nxt = bus.PWR ? OP_PNL_WR : OP_PNL_RD;
        else if (w_cpu_wr)
            w_op_nxt = OP_CPU_WR;
        else if (w_cpu_rd)
            w_op_nxt = OP_CPU_RD;
        else if (w_pnl)
            w_op_nxt = bus.PWR ? OP_PNL_WR : OP_PNL_RD;
    end

    // CPU is stalled when the panel is forced in or a read loses to a write.
    assign bus.STALL_n = !sys_rst_n ||
                         !((w_cpu_wr || w_cpu_rd) && (w_force || (w_cpu_wr && w_cpu_rd)));

    always_ff @(posedge sysclk) begin
        if (!sys_rst_n) begin
            r_op         <= OP_IDLE;
            r_rrf_n      <= 1'b1;
            r_wrf_n      <= 1'b1;
            r_addr_sel   <= 1'b0;
            r_pack       <= 1'b0;
            r_pnl_busy   <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_paddr_q    <= '0;
            r_pdata      <= '0;
        end else begin
            r_op       <= w_op_nxt;
            r_rrf_n    <= !((w_op_nxt == OP_CPU_RD) || (w_op_nxt == OP_PNL_RD));
            r_wrf_n    <= !((w_op_nxt == OP_CPU_WR) || (w_op_nxt == OP_PNL_WR));
            r_addr_sel <= (w_op_nxt == OP_PNL_RD) || (w_op_nxt == OP_PNL_WR);
            r_pack     <= w_op_is_pnl;

            if (w_pnl_grant)
                r_pnl_busy <= 1'b1;
            else if (w_op_is_pnl)
                r_pnl_busy <= 1'b0;

            if (w_pnl_grant)
                r_paddr_q <= bus.PADDR;

            if (r_op == OP_PNL_RD)
                r_pdata <= bus.RF_DATA;

            if (!bus.PREQ || w_pnl_grant)
                r_starve_cnt <= 4'd0;
            else if (w_pnl && (r_starve_cnt != c_LIMIT))
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign bus.RRF_n    = r_rrf_n;
    assign bus.WRF_n    = r_wrf_n;
    assign bus.ERF_n    = r_rrf_n && r_wrf_n;
    assign bus.ADDR_SEL = r_addr_sel;
    assign bus.PADDR_Q  = r_paddr_q;
    assign bus.PACK     = r_pack;
    assign bus.PDATA    = r_pdata;

endmodule
`default_nettype wire

// File: tb/tb_rf_access_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_access_sched
// Purpose  : Directed self-checking bench for the register file port scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_access_sched;

    localparam int c_DW = 16;
    localparam int c_AW = 4;

    logic sysclk;
    logic sys_rst_n;
    int   checks;
    int   errors;

    rf_access_sched_if #(.DW(c_DW), .AW(c_AW)) bus ();

    rf_access_sched #(
        .STARVE_LIMIT (4),
        .DW           (c_DW),
        .AW           (c_AW)
    ) dut (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.IDBS    = 5'd0;
        bus.LCS_n   = 1'b0;
        bus.WRTRF   = 1'b0;
        bus.PREQ    = 1'b0;
        bus.PWR     = 1'b0;
        bus.PADDR   = '0;
        bus.RF_DATA = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        sys_rst_n = 1'b0;
        bus.IDBS  = 5'd5;
        bus.LCS_n = 1'b1;
        bus.PREQ  = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.RRF_n, bus.WRF_n, bus.ERF_n} !== 3'b111) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 111", {bus.RRF_n, bus.WRF_n, bus.ERF_n});
        end
        checks++;
        if (bus.PACK !== 1'b0 || bus.ADDR_SEL !== 1'b0) begin
            errors++;
            $display("FAIL reset_pack_sel: got PACK=%b ADDR_SEL=%b expected 0 0", bus.PACK, bus.ADDR_SEL);
        end
        checks++;
        if (bus.STALL_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: got %b expected 1", bus.STALL_n);
        end
        checks++;
        if (bus.PDATA !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pdata: got %h expected 0000", bus.PDATA);
        end
        idle_inputs();
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read();
        bus.IDBS  = 5'd5;
        bus.LCS_n = 1'b1;
        #1;
        checks++;
        if (bus.STALL_n !== 1'b1) begin
            errors++;
            $display("FAIL cpu_rd_stall: got %b expected 1", bus.STALL_n);
        end
        tick();
        checks++;
        if ({bus.RRF_n, bus.WRF_n, bus.ERF_n, bus.ADDR_SEL} !== 4'b0100) begin
            errors++;
            $display("FAIL cpu_rd_strobe: got %b expected 0100",
                     {bus.RRF_n, bus.WRF_n, bus.ERF_n, bus.ADDR_SEL});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_cpu_qualify();
        bus.IDBS  = 5'd5;
        bus.LCS_n = 1'b0;
        tick();
        checks++;
        if ({bus.RRF_n, bus.ERF_n} !== 2'b11) begin
            errors++;
            $display("FAIL qual_lcs_low: got %b expected 11", {bus.RRF_n, bus.ERF_n});
        end
        bus.IDBS  = 5'd4;
        bus.LCS_n = 1'b1;
        tick();
        checks++;
        if ({bus.RRF_n, bus.ERF_n} !== 2'b11) begin
            errors++;
            $display("FAIL qual_idbs4: got %b expected 11", {bus.RRF_n, bus.ERF_n});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_conflict();
        bus.WRTRF = 1'b1;
        bus.IDBS  = 5'd5;
        bus.LCS_n = 1'b1;
        #1;
        checks++;
        if (bus.STALL_n !== 1'b0) begin
            errors++;
            $display("FAIL conflict_stall: got %b expected 0", bus.STALL_n);
        end
        tick();
        checks++;
        if ({bus.RRF_n, bus.WRF_n} !== 2'b10) begin
            errors++;
            $display("FAIL conflict_write: got %b expected 10", {bus.RRF_n, bus.WRF_n});
        end
        bus.WRTRF = 1'b0;
        #1;
        checks++;
        if (bus.STALL_n !== 1'b1) begin
            errors++;
            $display("FAIL conflict_held_stall: got %b expected 1", bus.STALL_n);
        end
        tick();
        checks++;
        if ({bus.RRF_n, bus.WRF_n} !== 2'b01) begin
            errors++;
            $display("FAIL conflict_read: got %b expected 01", {bus.RRF_n, bus.WRF_n});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_panel_read();
        bus.PREQ    = 1'b1;
        bus.PWR     = 1'b0;
        bus.PADDR   = 4'hA;
        bus.RF_DATA = 16'h1234;
        tick();
        checks++;
        if ({bus.RRF_n, bus.WRF_n, bus.ADDR_SEL, bus.PACK} !== 4'b0110 || bus.PADDR_Q !== 4'hA) begin
            errors++;
            $display("FAIL pnl_rd_grant: got strobes %b PADDR_Q %h expected 0110 a",
                     {bus.RRF_n, bus.WRF_n, bus.ADDR_SEL, bus.PACK}, bus.PADDR_Q);
        end
        tick();
        checks++;
        if (bus.PACK !== 1'b1 || bus.PDATA !== 16'h1234) begin
            errors++;
            $display("FAIL pnl_rd_ack: got PACK=%b PDATA=%h expected 1 1234", bus.PACK, bus.PDATA);
        end
        bus.RF_DATA = 16'h0000;
        tick();
        checks++;
        if ({bus.PACK, bus.ERF_n, bus.ADDR_SEL} !== 3'b010) begin
            errors++;
            $display("FAIL pnl_no_regrant: got PACK/ERF_n/ADDR_SEL %b expected 010",
                     {bus.PACK, bus.ERF_n, bus.ADDR_SEL});
        end
        checks++;
        if (bus.PDATA !== 16'h1234) begin
            errors++;
            $display("FAIL pnl_pdata_hold: got %h expected 1234", bus.PDATA);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        bus.WRTRF = 1'b1;
        bus.PREQ  = 1'b1;
        bus.PWR   = 1'b1;
        bus.PADDR = 4'h5;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.STALL_n !== 1'b1) begin
                errors++;
                $display("FAIL starve_deny_stall[%0d]: got %b expected 1", i, bus.STALL_n);
            end
            tick();
            checks++;
            if ({bus.WRF_n, bus.ADDR_SEL} !== 2'b00) begin
                errors++;
                $display("FAIL starve_deny[%0d]: got WRF_n/ADDR_SEL %b expected 00",
                         i, {bus.WRF_n, bus.ADDR_SEL});
            end
        end
        #1;
        checks++;
        if (bus.STALL_n !== 1'b0) begin
            errors++;
            $display("FAIL starve_force_stall: got %b expected 0", bus.STALL_n);
        end
        tick();
        checks++;
        if ({bus.WRF_n, bus.RRF_n, bus.ADDR_SEL} !== 3'b011 || bus.PADDR_Q !== 4'h5) begin
            errors++;
            $display("FAIL starve_force_grant: got %b PADDR_Q %h expected 011 5",
                     {bus.WRF_n, bus.RRF_n, bus.ADDR_SEL}, bus.PADDR_Q);
        end
        #1;
        checks++;
        if (bus.STALL_n !== 1'b1) begin
            errors++;
            $display("FAIL starve_post_stall: got %b expected 1", bus.STALL_n);
        end
        tick();
        checks++;
        if ({bus.PACK, bus.WRF_n, bus.ADDR_SEL} !== 3'b100) begin
            errors++;
            $display("FAIL starve_ack: got PACK/WRF_n/ADDR_SEL %b expected 100",
                     {bus.PACK, bus.WRF_n, bus.ADDR_SEL});
        end
        bus.PREQ = 1'b0;
        tick();
        // A fresh request against continuous writes is denied again, so the counter restarted.
        bus.PREQ = 1'b1;
        tick();
        checks++;
        if ({bus.WRF_n, bus.ADDR_SEL, bus.PACK} !== 3'b000) begin
            errors++;
            $display("FAIL starve_cnt_cleared: got %b expected 000", {bus.WRF_n, bus.ADDR_SEL, bus.PACK});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_op();
        bus.PREQ    = 1'b1;
        bus.PWR     = 1'b0;
        bus.PADDR   = 4'h3;
        bus.RF_DATA = 16'hBEEF;
        tick();
        checks++;
        if ({bus.RRF_n, bus.ADDR_SEL} !== 2'b01) begin
            errors++;
            $display("FAIL midrst_grant: got %b expected 01", {bus.RRF_n, bus.ADDR_SEL});
        end
        sys_rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.PACK, bus.RRF_n, bus.WRF_n, bus.ERF_n, bus.ADDR_SEL} !== 5'b01110) begin
            errors++;
            $display("FAIL midrst_outputs: got %b expected 01110",
                     {bus.PACK, bus.RRF_n, bus.WRF_n, bus.ERF_n, bus.ADDR_SEL});
        end
        checks++;
        if (bus.PDATA !== 16'h0000 || bus.PADDR_Q !== 4'h0) begin
            errors++;
            $display("FAIL midrst_data: got PDATA=%h PADDR_Q=%h expected 0000 0", bus.PDATA, bus.PADDR_Q);
        end
        idle_inputs();
        sys_rst_n = 1'b1;
        tick();
        checks++;
        if (bus.PACK !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_ack: got %b expected 0", bus.PACK);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        sys_rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_cpu_qualify();
        test_conflict();
        test_panel_read();
        test_starvation();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
